// File: rtl/cpu_types_pkg.sv
// Shared CPU types: 32-bit word, instruction-cache address field widths,
// frame record and cache controller states.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam int IBYT_W = 2;
   localparam int IIDX_W = 4;
   localparam int ITAG_W = 32 - IIDX_W - IBYT_W;

   typedef struct packed {
      logic              valid;
      logic [ITAG_W-1:0] tag;
      word_t             data;
   } icachef_t;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking
// single-word refill and saturating hit/miss counters.
module icache
   import cpu_types_pkg::*;
#(
   parameter int NSETS = 16,
   parameter int TAGW  = 26
) (
   input  logic  CLK,
   input  logic  nRST,
   input  logic  imemREN,
   input  word_t imemaddr,
   output logic  ihit,
   output word_t imemload,
   output logic  iREN,
   output word_t iaddr,
   input  logic  iwait,
   input  word_t iload,
   output word_t hitcnt,
   output word_t misscnt
);

   localparam int    IDXW    = $clog2(NSETS);
   localparam word_t CNT_MAX = 32'hFFFF_FFFF;

   icachef_t      frames_r [NSETS];
   icache_state_t state_r;
   icache_state_t next_state_s;
   word_t         miss_addr_r;
   word_t         hitcnt_r;
   word_t         misscnt_r;

   logic [IDXW-1:0] idx_s;
   logic [TAGW-1:0] tag_s;
   logic [IDXW-1:0] fill_idx_s;
   logic            hit_s;
   logic            miss_start_s;
   logic            fill_done_s;
   logic            unused_s;

   assign idx_s      = imemaddr[IDXW+1:2];
   assign tag_s      = imemaddr[31 -: TAGW];
   assign fill_idx_s = miss_addr_r[IDXW+1:2];
   assign hit_s      = frames_r[idx_s].valid && (frames_r[idx_s].tag == tag_s);
   // Byte offsets never select anything in a word-wide frame.
   assign unused_s   = ^{imemaddr[1:0], miss_addr_r[1:0]};

   assign hitcnt  = hitcnt_r;
   assign misscnt = misscnt_r;

   // Lookup and fill control; hit data must reach the datapath in the same cycle.
   always_comb begin
      next_state_s = state_r;
      ihit         = 1'b0;
      imemload     = '0;
      iREN         = 1'b0;
      iaddr        = '0;
      miss_start_s = 1'b0;
      fill_done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (imemREN && hit_s) begin
               ihit     = 1'b1;
               imemload = frames_r[idx_s].data;
            end else if (imemREN) begin
               miss_start_s = 1'b1;
               next_state_s = FILL;
            end else begin
               next_state_s = IDLE;
            end
         end
         FILL: begin
            // The fill always targets the latched address, even if the datapath redirected.
            iREN  = 1'b1;
            iaddr = {miss_addr_r[31:2], 2'b00};
            if (!iwait) begin
               fill_done_s  = 1'b1;
               next_state_s = IDLE;
            end else begin
               next_state_s = FILL;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Controller state register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Miss address captured on the IDLE->FILL transition.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         miss_addr_r <= '0;
      end else if (miss_start_s) begin
         miss_addr_r <= imemaddr;
      end
   end

   // Frame array; a completed fill overwrites its frame unconditionally.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NSETS; i++) begin
            frames_r[i] <= '0;
         end
      end else if (fill_done_s) begin
         frames_r[fill_idx_s] <= '{valid: 1'b1, tag: miss_addr_r[31 -: TAGW], data: iload};
      end
   end

   // Saturating performance counters.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hitcnt_r  <= '0;
         misscnt_r <= '0;
      end else begin
         if (ihit && (hitcnt_r != CNT_MAX)) begin
            hitcnt_r <= hitcnt_r + 32'd1;
         end
         if (miss_start_s && (misscnt_r != CNT_MAX)) begin
            misscnt_r <= misscnt_r + 32'd1;
         end
      end
   end

endmodule
